// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers used by
// both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; RESET_VAL sets the
// value both flops take while reset is asserted.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; defining UART_RX_PARITY_EN adds one even-parity
// bit between data bit 7 and stop. Output byte uses a valid/ready register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err,
  output uart_state_t state_dbg
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF  = half_bit(CPB);
  localparam int CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(HALF + 1);

  // Handshake: rx_data is offered while rx_valid=1 and is consumed on any
  // rising clk_100m edge where rx_valid && rx_ready; it holds steady otherwise.

  uart_state_t      state, state_nxt;
  logic             rx_s, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic             s0, s1, maj;
  logic [7:0]       shift_reg;
  logic             at_smp, bit_end;
  logic             byte_done, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic             par_acc, par_fail, par_bad;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk_100m),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign state_dbg = state;
  assign at_smp    = (cnt == SMP_C);
  assign bit_end   = (cnt == CNT_LAST);
  // Majority of the samples taken at mid-1, mid and (live) mid+1.
  assign maj       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rx_s && rx_prev) state_nxt = ST_START;
      ST_START: begin
        if (at_smp && maj) state_nxt = ST_IDLE;
        else if (bit_end)  state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = ST_PARITY;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:    if (bit_end) state_nxt = ST_STOP;
`endif
      ST_STOP:      if (at_smp) state_nxt = maj ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (rx_s && bit_end) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_bad = (state == ST_STOP) && at_smp && !maj;
`ifdef UART_RX_PARITY_EN
    par_bad   = (state == ST_PARITY) && at_smp && (maj != par_acc);
    byte_done = (state == ST_STOP) && at_smp && maj && !par_fail;
`else
    byte_done = (state == ST_STOP) && at_smp && maj;
`endif
  end

  // Bit timer restarts on every state change and bit boundary; in WAIT_IDLE
  // any low sample restarts the one-bit idle qualification.
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shift_reg <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_acc   <= 1'b0;
      par_fail  <= 1'b0;
`endif
    end else begin
      rx_prev <= rx_s;
      if (state == ST_IDLE || state_nxt != state || bit_end ||
          (state == ST_WAIT_IDLE && !rx_s))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (cnt == SMP_A) s0 <= rx_s;
      if (cnt == SMP_B) s1 <= rx_s;
      if (state == ST_IDLE && state_nxt == ST_START) begin
        bit_cnt <= 3'd0;
`ifdef UART_RX_PARITY_EN
        par_acc  <= 1'b0;
        par_fail <= 1'b0;
`endif
      end
      if (state == ST_DATA && at_smp) begin
        shift_reg <= {maj, shift_reg[7:1]};
`ifdef UART_RX_PARITY_EN
        par_acc   <= par_acc ^ maj;
`endif
      end
      if (state == ST_DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
      if (par_bad) par_fail <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (rx_valid && !rx_ready) overrun <= 1'b1;
        else begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= par_bad;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the clk_100m frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have port clk_100m, input, width 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have port rx, input, width 1: asynchronous serial line from the FTDI, idle high.
REQ-006 SHALL have port rx_data, output, width 8: received byte, LSB first on the line.
REQ-007 SHALL have port rx_valid, output, width 1: rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_ready, input, width 1: consumer accepts the byte when rx_valid && rx_ready.
REQ-009 SHALL have port frame_err, output, width 1: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, width 1: one-cycle pulse when a completed byte is dropped.
REQ-011 SHALL have port parity_err, output, width 1: one-cycle pulse on even-parity mismatch; tied 0 when parity is compiled out.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; all decisions use the synchronized value.
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD with integer truncation (868 at defaults) and HALF = CLKS_PER_BIT/2 (434).
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (only with the macro), STOP and WAIT_IDLE.
REQ-015 IDLE: a synchronized 1->0 edge SHALL enter START and clear the bit counter.
REQ-016 START: at HALF cycles, a majority sample of 1 SHALL return to IDLE with no output; a sample of 0 SHALL enter DATA.
REQ-017 DATA: each bit SHALL be majority-of-3, sampled at mid-bit-1, mid-bit and mid-bit+1, and shifted in LSB first; after bit 7 the FSM SHALL enter PARITY or STOP.
REQ-018 STOP: a sample of 1 SHALL complete the byte and return to IDLE; a sample of 0 SHALL pulse frame_err, discard the byte and enter WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL hold until the synchronized rx has been 1 for one full CLKS_PER_BIT, then enter IDLE; a break condition therefore produces exactly one frame_err.
REQ-020 On completion, rx_valid SHALL rise on the cycle after the stop-bit sample and rx_data SHALL be stable while rx_valid && !rx_ready.
REQ-021 A byte that completes while rx_valid=1 and rx_ready=0 SHALL be dropped: overrun pulses and the held rx_data is unchanged.
REQ-022 A byte that completes in the same cycle as a handshake (rx_valid && rx_ready) SHALL be loaded with rx_valid kept at 1 and no overrun.
REQ-023 A handshake with no completing byte SHALL clear rx_valid on the next cycle.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE, the synchronizer flops SHALL be 1, all counters 0, rx_data=0x00, and rx_valid, frame_err, overrun and parity_err 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL ignore line activity until a new 1->0 edge.

Configuration
REQ-026 When UART_RX_PARITY_EN is defined, the block SHALL expect one even-parity bit between bit 7 and stop; on mismatch it SHALL pulse parity_err and discard the byte but still check the stop bit.
REQ-027 When UART_RX_PARITY_EN is undefined, the frame SHALL be 8N1, the PARITY state SHALL be absent, and parity_err SHALL be constant 0.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum and the CLKS_PER_BIT and HALF computation functions, shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module named sync_2ff with a reset value parameter, set to 1 here.

Verification
REQ-030 Send 0xA5 in 8N1 at 115200 with rx_ready=1 -> rx_valid pulses once with rx_data=0xA5; frame_err and overrun stay 0.
REQ-031 Glitch rx low for 200 cycles (shorter than HALF) -> no rx_valid and FSM back in IDLE.
REQ-032 Send 0x3C with a stop bit of 0 -> one frame_err pulse, no rx_valid; hold rx low for 3 bit times, release, then send 0x55 -> rx_data=0x55.
REQ-033 With rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses once; then assert rx_ready with 0x33 completing in the same cycle -> rx_data=0x33, rx_valid stays 1.
REQ-034 Assert rst for 5 cycles mid-way through bit 4 of 0xFF, then send 0x81 -> only 0x81 is delivered.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_err pulses and no rx_valid; send 0x07 with parity bit 1 -> rx_data=0x07.
